gpo_event_capture: RTL

Captures every change on the processor's 32-bit general-purpose output bus, tags it with a free-running cycle timestamp, and buffers it in a small FIFO for a downstream consumer (host bridge, checker or logic analyser port). Sits directly downstream of the MicroBlaze `top` block, consuming XGPO and XREADY on the same clock. Overflow is reported rather than back-pressuring the processor, which has no stall path on GPO.

---
 rtl/gpo_event_pkg.sv | 16 +
 rtl/gpo_event_capture_if.sv | 14 +
 rtl/gpo_event_fifo.sv | 59 +++++
 rtl/gpo_event_capture.sv | 97 +++++++++
 4 files changed

// File: rtl/gpo_event_pkg.sv
// rtl/gpo_event_pkg.sv - shared constants, entry type and helpers for GPO event capture
package gpo_event_pkg;
    localparam int GPO_W        = 32;
    localparam int DEPTH_DEF    = 8;
    localparam int TS_WIDTH_DEF = 16;
    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0] ev_time;
        logic [GPO_W-1:0]        ev_data;
    } gpo_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/gpo_event_capture_if.sv
// rtl/gpo_event_capture_if.sv - event stream handshake between capture block and consumer
interface gpo_event_capture_if
    import gpo_event_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF
);
    logic                ev_valid;
    logic                ev_ready;
    logic [GPO_W-1:0]    ev_data;
    logic [TS_WIDTH-1:0] ev_time;

    modport master (output ev_valid, output ev_data, output ev_time, input  ev_ready);
    modport slave  (input  ev_valid, input  ev_data, input  ev_time, output ev_ready);
endinterface

// File: rtl/gpo_event_fifo.sv
// rtl/gpo_event_fifo.sv - synchronous first-word-fall-through FIFO with flush and level
module gpo_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/gpo_event_capture.sv
// rtl/gpo_event_capture.sv - timestamps every GPO bus change and queues it for a consumer
module gpo_event_capture
    import gpo_event_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TS_WIDTH = TS_WIDTH_DEF
) (
    input  logic                     XCLK,
    input  logic                     XRESET,
    input  logic [GPO_W-1:0]         XGPO,
    input  logic                     XREADY,
    input  logic                     clear,
    gpo_event_capture_if.master      ev,
    output logic [$clog2(DEPTH):0]   ev_level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    typedef struct packed {
        logic [TS_WIDTH-1:0] ev_time;
        logic [GPO_W-1:0]    ev_data;
    } entry_t;

    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [GPO_W-1:0]    gpo_q, gpo_d;
    logic                rdy_q, rdy_d;
    logic [GPO_W-1:0]    gpo_last_q, gpo_last_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_count_q, drop_count_d;

    logic   is_event, drop, full, empty;
    entry_t push_entry, head_entry;

    assign is_event   = rdy_q && (gpo_q != gpo_last_q);
    // Full with a pop pending is not a drop; the FIFO takes both.
    assign drop       = is_event && !clear && full && !ev.ev_ready;
    assign push_entry = '{ev_time: ts_q, ev_data: gpo_q};

    always_comb begin
        ts_cnt_d     = ts_cnt_q + 1'b1;
        ts_d         = ts_cnt_q;
        gpo_d        = XGPO;
        rdy_d        = XREADY;
        gpo_last_d   = is_event ? gpo_q : gpo_last_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = sat_inc8(drop_count_q);
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRESET) begin
            ts_cnt_q     <= '0;
            ts_q         <= '0;
            gpo_q        <= '0;
            rdy_q        <= 1'b0;
            gpo_last_q   <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_cnt_q     <= ts_cnt_d;
            ts_q         <= ts_d;
            gpo_q        <= gpo_d;
            rdy_q        <= rdy_d;
            gpo_last_q   <= gpo_last_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    gpo_event_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk       (XCLK),
        .rst       (XRESET),
        .flush     (clear),
        .push      (is_event),
        .push_data (push_entry),
        .pop       (ev.ev_ready),
        .head      (head_entry),
        .full      (full),
        .empty     (empty),
        .level     (ev_level)
    );

    assign ev.ev_valid = !empty;
    assign ev.ev_data  = head_entry.ev_data;
    assign ev.ev_time  = head_entry.ev_time;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
endmodule
